otter_pl_fetch: RTL
===================

Name: otter_pl_fetch

Overview:
Instruction-fetch (IF) stage of the pipelined OTTER MCU.
- Owns the PC and the instruction-memory read handshake.
- Holds the IF/ID pipeline register, whose opcode/func3/func7 fields drive the pipelined decoder.
- Consumes the decoder's PC_SOURCE select and resulting targets: redirects fetch, squashes wrong-path instructions, and buffers one response under stall.

Parameters:
RESET_VEC, 32'h0000_0000, PC value loaded at reset
NOP_INSTR, 32'h0000_0013, IF_ID_IR value when the slot is invalid (addi x0,x0,0)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
PC_SOURCE  in  3  decoder select: 0 pc+4, 1 jalr, 2 branch, 3 jal, 4 trap (mtvec), 5 mret (mepc), 6/7 treated as 0
REDIRECT  in  1  PC_SOURCE is valid this cycle (instruction in EX)
JALR_TGT, BRANCH_TGT, JAL_TGT, MTVEC, MEPC  in  32 each  redirect targets
STALL  in  1  hazard unit: hold IF/ID
IMEM_REQ  out  1  single-cycle read request pulse
IMEM_ADDR  out  32  word-aligned fetch address, valid with IMEM_REQ
IMEM_RVALID  in  1  read data valid, at least 1 cycle after IMEM_REQ
IMEM_RDATA  in  32  instruction word
IF_ID_VALID  out  1  IF/ID holds a live instruction
IF_ID_IR  out  32  instruction
IF_ID_PC  out  32  its address
CU_OPCODE  out  7  IF_ID_IR[6:0]
CU_FUNC3  out  3  IF_ID_IR[14:12]
CU_FUNC7  out  7  IF_ID_IR[31:25]

Behaviour:
Reset (async, RST_N=0):
- PC=RESET_VEC, state=S_RESET, IMEM_REQ=0, IMEM_ADDR=RESET_VEC.
- IF_ID_VALID=0, IF_ID_IR=NOP_INSTR, IF_ID_PC=0.
- kill flag=0, buffer empty.

FSM:
- S_RESET: after the first edge with RST_N=1, go to S_ISSUE.
- S_ISSUE: IMEM_REQ=1, IMEM_ADDR=PC for exactly one cycle, then go to S_WAIT.
- S_WAIT: IMEM_REQ=0; wait for IMEM_RVALID.
  - Response with kill=1: discard it, clear kill, go to S_ISSUE.
  - Response with STALL=0: load IF/ID (VALID=1, IR=RDATA, PC=PC), PC<=PC+4 (wraps modulo 2^32), go to S_ISSUE.
  - Response with STALL=1: capture RDATA/PC into the one-entry buffer, PC<=PC+4, go to S_BUF.
- S_BUF: no request issued. On the first cycle with STALL=0: IF/ID<=buffer, go to S_ISSUE.

Stall and ordering rules:
- Only one request outstanding at any time; IMEM_RVALID outside S_WAIT is ignored.
- With STALL=1, all IF/ID outputs hold their values.

Redirect (REDIRECT=1 and PC_SOURCE in 1..5):
- PC<=selected target with bits[1:0] forced to 0.
- IF_ID_VALID<=0 and IF_ID_IR<=NOP_INSTR (flush); buffer emptied.
- If state is S_WAIT, set kill=1 and stay in S_WAIT.
- Otherwise go to S_ISSUE next cycle.
- Redirect has priority over STALL and over a same-cycle IMEM_RVALID; that response is treated as killed.

Latency:
- Redirect outside S_WAIT: target request 1 cycle later.
- Redirect in S_WAIT: target request 1 cycle after the stale response arrives.

Reset mid-operation:
- All state returns to reset values immediately.
- A response to a pre-reset request arriving in S_RESET/S_ISSUE is ignored.

CU_* fields are combinational slices of IF_ID_IR.

Optional Feature:
Macro: OTTER_FETCH_PERF_EN.
- Defined: adds outputs PERF_FETCHES[31:0] and PERF_FLUSHES[31:0], both reset to 0 and wrapping.
  - PERF_FETCHES increments on each IF/ID load of a live instruction (direct or from buffer).
  - PERF_FLUSHES increments on each accepted redirect.
- Undefined: both ports exist and are tied to 0; no counter flops.

Test Plan:
- Reset with RESET_VEC=0, RST_N released -> IMEM_REQ=1, IMEM_ADDR=0x0 on the second edge after release; IF_ID_VALID=0 until the first response.
- 1-cycle memory returns 0x00500093 for 0x0 -> IF_ID_VALID=1, IF_ID_IR=0x00500093, CU_OPCODE=0x13, CU_FUNC3=0, IF_ID_PC=0x0; next IMEM_ADDR=0x4.
- STALL=1 when the 0x8 response arrives, held 3 cycles -> IF/ID unchanged, no IMEM_REQ during stall; on release IF_ID_PC=0x8, then IMEM_ADDR=0xC.
- 3-cycle memory with the 0x10 request outstanding, REDIRECT=1, PC_SOURCE=3, JAL_TGT=0x100 -> IF_ID_VALID=0, stale 0x10 data never appears, next IMEM_ADDR=0x100.
- REDIRECT with PC_SOURCE=4, MTVEC=0x202 -> IMEM_ADDR=0x200; REDIRECT with PC_SOURCE=5, MEPC=0x44 -> IMEM_ADDR=0x44; PC_SOURCE=6 -> sequential 0x48.
- REDIRECT, STALL and IMEM_RVALID in the same cycle -> redirect wins: flush, response dropped, next IMEM_ADDR=target; with OTTER_FETCH_PERF_EN, PERF_FLUSHES increments by exactly 1.

Source files
------------

// File: rtl/otter_pl_fetch.sv
// Instruction-fetch stage of the pipelined OTTER MCU: PC, imem read handshake and IF/ID register.
// Define OTTER_FETCH_PERF_EN to add live PERF_FETCHES/PERF_FLUSHES counters (tied to 0 otherwise).
module otter_pl_fetch #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [2:0]  PC_SOURCE,
  input  logic        REDIRECT,
  input  logic [31:0] JALR_TGT,
  input  logic [31:0] BRANCH_TGT,
  input  logic [31:0] JAL_TGT,
  input  logic [31:0] MTVEC,
  input  logic [31:0] MEPC,
  input  logic        STALL,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic        IF_ID_VALID,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_PC,
  output logic [6:0]  CU_OPCODE,
  output logic [2:0]  CU_FUNC3,
  output logic [6:0]  CU_FUNC7,
  output logic [31:0] PERF_FETCHES,
  output logic [31:0] PERF_FLUSHES
);

  typedef enum logic [1:0] {
    S_RESET,
    S_ISSUE,
    S_WAIT,
    S_BUF
  } fetch_state_t;

  fetch_state_t state_q, state_d;
  logic         kill_q, kill_d;

  logic [31:0]  pc_q;
  logic [31:0]  buf_ir_q;
  logic [31:0]  buf_pc_q;
  logic         ifid_valid_q;
  logic [31:0]  ifid_ir_q;
  logic [31:0]  ifid_pc_q;

  logic         redirect_ok;
  logic [31:0]  sel_tgt;
  logic [31:0]  redirect_tgt;

  logic         imem_req;
  logic         flush;
  logic         pc_advance;
  logic         buf_capture;
  logic         load_direct;
  logic         load_buf;

  // PC_SOURCE 0, 6 and 7 mean "keep fetching sequentially", so they never redirect.
  always_comb begin
    redirect_ok = 1'b0;
    sel_tgt     = pc_q;
    if (REDIRECT) begin
      case (PC_SOURCE)
        3'd1: begin redirect_ok = 1'b1; sel_tgt = JALR_TGT;   end
        3'd2: begin redirect_ok = 1'b1; sel_tgt = BRANCH_TGT; end
        3'd3: begin redirect_ok = 1'b1; sel_tgt = JAL_TGT;    end
        3'd4: begin redirect_ok = 1'b1; sel_tgt = MTVEC;      end
        3'd5: begin redirect_ok = 1'b1; sel_tgt = MEPC;       end
        default: ;
      endcase
    end
  end

  assign redirect_tgt = sel_tgt & 32'hFFFF_FFFC;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_RESET;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
    end
  end

  // A redirect beats stall and any same-cycle response; if the response is still in flight
  // we must stay in S_WAIT and drop it on arrival to keep a single request outstanding.
  always_comb begin
    state_d     = state_q;
    kill_d      = kill_q;
    imem_req    = 1'b0;
    flush       = 1'b0;
    pc_advance  = 1'b0;
    buf_capture = 1'b0;
    load_direct = 1'b0;
    load_buf    = 1'b0;

    if (redirect_ok) begin
      flush = 1'b1;
      if (state_q == S_WAIT && !IMEM_RVALID) begin
        kill_d = 1'b1;
      end else begin
        kill_d  = 1'b0;
        state_d = S_ISSUE;
      end
    end else begin
      case (state_q)
        S_RESET: state_d = S_ISSUE;
        S_ISSUE: begin
          imem_req = 1'b1;
          state_d  = S_WAIT;
        end
        S_WAIT: begin
          if (IMEM_RVALID) begin
            state_d = S_ISSUE;
            if (kill_q) begin
              kill_d = 1'b0;
            end else if (STALL) begin
              buf_capture = 1'b1;
              pc_advance  = 1'b1;
              state_d     = S_BUF;
            end else begin
              load_direct = 1'b1;
              pc_advance  = 1'b1;
            end
          end
        end
        S_BUF: begin
          if (!STALL) begin
            load_buf = 1'b1;
            state_d  = S_ISSUE;
          end
        end
        default: state_d = S_RESET;
      endcase
    end
  end

  // Buffer occupancy is implied by S_BUF, so a flush empties it simply by leaving that state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pc_q         <= RESET_VEC;
      buf_ir_q     <= NOP_INSTR;
      buf_pc_q     <= 32'h0;
      ifid_valid_q <= 1'b0;
      ifid_ir_q    <= NOP_INSTR;
      ifid_pc_q    <= 32'h0;
    end else begin
      if (flush) begin
        pc_q <= redirect_tgt;
      end else if (pc_advance) begin
        pc_q <= pc_q + 32'd4;
      end

      if (buf_capture) begin
        buf_ir_q <= IMEM_RDATA;
        buf_pc_q <= pc_q;
      end

      if (flush) begin
        ifid_valid_q <= 1'b0;
        ifid_ir_q    <= NOP_INSTR;
      end else if (load_direct) begin
        ifid_valid_q <= 1'b1;
        ifid_ir_q    <= IMEM_RDATA;
        ifid_pc_q    <= pc_q;
      end else if (load_buf) begin
        ifid_valid_q <= 1'b1;
        ifid_ir_q    <= buf_ir_q;
        ifid_pc_q    <= buf_pc_q;
      end
    end
  end

  assign IMEM_REQ    = imem_req;
  assign IMEM_ADDR   = pc_q;
  assign IF_ID_VALID = ifid_valid_q;
  assign IF_ID_IR    = ifid_ir_q;
  assign IF_ID_PC    = ifid_pc_q;
  assign CU_OPCODE   = ifid_ir_q[6:0];
  assign CU_FUNC3    = ifid_ir_q[14:12];
  assign CU_FUNC7    = ifid_ir_q[31:25];

`ifdef OTTER_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (load_direct || load_buf) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (flush) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign PERF_FETCHES = fetch_cnt_q;
  assign PERF_FLUSHES = flush_cnt_q;
`else
  assign PERF_FETCHES = 32'h0;
  assign PERF_FLUSHES = 32'h0;
`endif

endmodule
